// File: rtl/uart_tx.sv
// UART transmitter that pulls bytes from a show-ahead FIFO and sends 8N1/8E1/8N2/8E2 frames.
// Supports back-to-back frames with no idle gap between them.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [7:0] fifo_rdata_i,
    input  logic       fifo_empty_i,
    output logic       fifo_re_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic             stop_idx;
    logic [7:0]       shift;
    logic             parity;
    logic             tx_q;

    logic bit_end;
    logic last_stop;
    logic pop;

    assign bit_end   = (bit_cnt == CNT_MAX);
    assign last_stop = (state == S_STOP) && bit_end && ((STOP_BITS == 1) || stop_idx);
    // Pops happen either from idle or on the very last stop cycle, so frames chain with no gap.
    assign pop       = !rst_i && en_i && !fifo_empty_i && ((state == S_IDLE) || last_stop);

    assign fifo_re_o = pop;
    assign done_o    = !rst_i && last_stop;
    assign busy_o    = (state != S_IDLE);
    assign tx_o      = tx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            parity   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            if ((state == S_IDLE) || bit_end) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        state  <= S_START;
                        shift  <= fifo_rdata_i;
                        parity <= ^fifo_rdata_i;
                        tx_q   <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_idx <= 3'd0;
                        tx_q    <= shift[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            stop_idx <= 1'b0;
                            if (PARITY_EN != 0) begin
                                state <= S_PARITY;
                                tx_q  <= parity;
                            end else begin
                                state <= S_STOP;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx_q    <= shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state    <= S_STOP;
                        stop_idx <= 1'b0;
                        tx_q     <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (last_stop) begin
                        stop_idx <= 1'b0;
                        if (pop) begin
                            state  <= S_START;
                            shift  <= fifo_rdata_i;
                            parity <= ^fifo_rdata_i;
                            tx_q   <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx_q  <= 1'b1;
                        end
                    end else if (bit_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (8N1 and 8E2, 4 clocks per bit) fed by FIFO models,
// with a scoreboard of expected bytes checked bit-by-bit against the serial line.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_a = 1'b0, en_b = 1'b0;
    logic [7:0] rdata_a = 8'h00, rdata_b = 8'h00;
    logic       empty_a = 1'b1, empty_b = 1'b1;
    logic       re_a, re_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en_a), .fifo_rdata_i(rdata_a),
        .fifo_empty_i(empty_a), .fifo_re_o(re_a), .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en_b), .fifo_rdata_i(rdata_b),
        .fifo_empty_i(empty_b), .fifo_re_o(re_b), .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
    );

    logic [7:0] fq_a[$], fq_b[$];
    logic [7:0] exp_q_a[$], exp_q_b[$];

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;
    int in_frame[2], fc[2], pops[2], dones[2], last_pop_cyc[2], pop_gap[2], busy_run[2], last_run[2];
    logic [7:0] cur[2];
    bit pend[2], popped_now[2];

    initial forever #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx, input int pe);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && pe != 0) return ^b;
        return 1'b1;
    endfunction

    task automatic refresh_fifo();
        empty_a = (fq_a.size() == 0);
        rdata_a = empty_a ? 8'h00 : fq_a[0];
        empty_b = (fq_b.size() == 0);
        rdata_b = empty_b ? 8'h00 : fq_b[0];
    endtask

    task automatic push(input int k, input logic [7:0] b);
        if (k == 0) begin
            fq_a.push_back(b);
            exp_q_a.push_back(b);
        end else begin
            fq_b.push_back(b);
            exp_q_b.push_back(b);
        end
        refresh_fifo();
    endtask

    task automatic mon(input int k, input logic tx, input logic busy, input logic done);
        int pe;
        int nbits;
        pe    = (k == 1) ? 1 : 0;
        nbits = (k == 0) ? 10 : 12;
        if (busy) busy_run[k]++;
        else begin
            if (busy_run[k] != 0) last_run[k] = busy_run[k];
            busy_run[k] = 0;
        end
        if (done) dones[k]++;
        if (in_frame[k] == 0 && tx == 1'b0) begin
            check_val($sformatf("start_after_pop_%0d", k), 32'(popped_now[k]), 32'd1);
            if (k == 0) begin
                check_val("frame_expected_0", 32'(exp_q_a.size() != 0), 32'd1);
                cur[0] = (exp_q_a.size() != 0) ? exp_q_a.pop_front() : 8'h00;
            end else begin
                check_val("frame_expected_1", 32'(exp_q_b.size() != 0), 32'd1);
                cur[1] = (exp_q_b.size() != 0) ? exp_q_b.pop_front() : 8'h00;
            end
            in_frame[k] = 1;
            fc[k] = 0;
        end
        if (in_frame[k] != 0) begin
            check_val($sformatf("tx_%0d_byte%0h_bit%0d", k, cur[k], fc[k] / CPB), 32'(tx),
                      32'(exp_bit(cur[k], fc[k] / CPB, pe)));
            check_val($sformatf("busy_in_frame_%0d", k), 32'(busy), 32'd1);
            check_val($sformatf("done_timing_%0d_c%0d", k, fc[k]), 32'(done),
                      32'(fc[k] == nbits * CPB - 1));
            fc[k]++;
            if (fc[k] == nbits * CPB) in_frame[k] = 0;
        end else begin
            check_val($sformatf("idle_busy_%0d", k), 32'(busy), 32'd0);
            check_val($sformatf("idle_done_%0d", k), 32'(done), 32'd0);
        end
    endtask

    // FIFO model and line monitor: pops take effect one negedge after the strobe is seen.
    always begin
        logic [7:0] dummy;
        @(negedge clk);
        cyc++;
        popped_now[0] = pend[0];
        popped_now[1] = pend[1];
        if (pend[0]) dummy = fq_a.pop_front();
        if (pend[1]) dummy = fq_b.pop_front();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        refresh_fifo();
        mon(0, tx_a, busy_a, done_a);
        mon(1, tx_b, busy_b, done_b);
        #4;
        if (re_a) begin
            check_val("re_while_empty_a", 32'(empty_a), 32'd0);
            pend[0] = 1'b1;
            pops[0]++;
            pop_gap[0] = cyc - last_pop_cyc[0];
            last_pop_cyc[0] = cyc;
        end
        if (re_b) begin
            check_val("re_while_empty_b", 32'(empty_b), 32'd0);
            pend[1] = 1'b1;
            pops[1]++;
            pop_gap[1] = cyc - last_pop_cyc[1];
            last_pop_cyc[1] = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int k, input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (dones[k] >= target) break;
            step(1);
        end
        check_val(tag, 32'(dones[k] >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_tx_a"}, 32'(tx_a), 32'd1);
        check_val({tag, "_busy_a"}, 32'(busy_a), 32'd0);
        check_val({tag, "_re_a"}, 32'(re_a), 32'd0);
        check_val({tag, "_done_a"}, 32'(done_a), 32'd0);
        check_val({tag, "_tx_b"}, 32'(tx_b), 32'd1);
        check_val({tag, "_busy_b"}, 32'(busy_b), 32'd0);
    endtask

    initial begin
        int p0;
        int d0;
        for (int k = 0; k < 2; k++) begin
            in_frame[k] = 0; fc[k] = 0; pops[k] = 0; dones[k] = 0;
            last_pop_cyc[k] = 0; pop_gap[k] = 0; busy_run[k] = 0; last_run[k] = 0;
            cur[k] = 8'h00; pend[k] = 1'b0; popped_now[k] = 1'b0;
        end

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_async");
        step(3);
        rst = 1'b0;
        step(2);

        // Single byte 0xA5
        en_a = 1'b1;
        push(0, 8'hA5);
        wait_done(0, 1, 200, "a5_done");
        step(3);
        check_val("a5_pops", 32'(pops[0]), 32'd1);
        check_val("a5_dones", 32'(dones[0]), 32'd1);
        check_val("a5_busy_len", 32'(last_run[0]), 32'd40);

        // Back-to-back 0x00 then 0xFF
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_done(0, 3, 300, "b2b_done");
        step(3);
        check_val("b2b_pop_gap", 32'(pop_gap[0]), 32'd40);
        check_val("b2b_busy_len", 32'(last_run[0]), 32'd80);
        check_val("b2b_pops", 32'(pops[0]), 32'd3);

        // Enable dropped mid-frame with the FIFO still holding data
        push(0, 8'h96);
        push(0, 8'h11);
        for (int i = 0; i < 100; i++) begin
            if (in_frame[0] != 0 && fc[0] >= 10) break;
            step(1);
        end
        en_a = 1'b0;
        wait_done(0, 4, 200, "en_drop_done");
        step(60);
        check_val("en_drop_pops", 32'(pops[0]), 32'd4);
        check_val("en_drop_dones", 32'(dones[0]), 32'd4);
        check_val("en_drop_fifo_left", 32'(fq_a.size()), 32'd1);
        en_a = 1'b1;
        wait_done(0, 5, 200, "en_resume_done");
        step(3);
        check_val("en_resume_pops", 32'(pops[0]), 32'd5);

        // Reset pulsed during data bit 3
        push(0, 8'h34);
        push(0, 8'h5A);
        for (int i = 0; i < 100; i++) begin
            if (in_frame[0] != 0 && fc[0] >= 18) break;
            step(1);
        end
        check_val("pre_reset_tx_low", 32'(tx_a), 32'd0);
        p0 = pops[0];
        d0 = dones[0];
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset_mid_frame");
        in_frame[0] = 0;
        step(1);
        rst = 1'b0;
        check_val("reset_no_done", 32'(dones[0]), 32'(d0));
        check_val("reset_no_pop", 32'(pops[0]), 32'(p0));
        wait_done(0, d0 + 1, 200, "after_reset_done");
        step(3);
        check_val("after_reset_pops", 32'(pops[0]), 32'(p0 + 1));
        check_val("after_reset_dones", 32'(dones[0]), 32'(d0 + 1));

        // A few random bytes, streamed
        d0 = dones[0];
        for (int i = 0; i < 4; i++) push(0, 8'($urandom_range(0, 255)));
        wait_done(0, d0 + 4, 400, "rand_a_done");
        step(3);

        // Parity + two stop bits, byte 0x07
        en_b = 1'b1;
        push(1, 8'h07);
        wait_done(1, 1, 200, "p07_done");
        step(3);
        check_val("p07_frame_len", 32'(last_run[1]), 32'd48);
        check_val("p07_pops", 32'(pops[1]), 32'd1);
        for (int i = 0; i < 3; i++) push(1, 8'($urandom_range(0, 255)));
        wait_done(1, 4, 400, "rand_b_done");
        step(3);
        check_val("rand_b_pop_gap", 32'(pop_gap[1]), 32'd48);
        check_val("rand_b_busy_len", 32'(last_run[1]), 32'd144);

        check_val("exp_q_a_empty", 32'(exp_q_a.size()), 32'd0);
        check_val("exp_q_b_empty", 32'(exp_q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk_i cycles per serial bit (legal range >= 2).
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 = append even-parity bit after data.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits (legal values 1 or 2).
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-006 SHALL have port en_i  input  1  transmitter enable; gates start of new frames only.
REQ-007 SHALL have port fifo_rdata_i  input  8  head-of-queue byte from upstream show-ahead sync FIFO, valid whenever fifo_empty_i=0.
REQ-008 SHALL have port fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-009 SHALL have port fifo_re_o  output  1  single-cycle pop strobe to upstream FIFO.
REQ-010 SHALL have port tx_o  output  1  serial line, idle high, registered.
REQ-011 SHALL have port busy_o  output  1  high while any frame bit (start..last stop) is on tx_o.
REQ-012 SHALL have port done_o  output  1  single-cycle pulse at completion of each frame.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-014 In IDLE, when en_i=1 and fifo_empty_i=0, SHALL in that same cycle assert fifo_re_o, latch fifo_rdata_i into the shift register, and transition to START at the next edge.
REQ-015 SHALL never assert fifo_re_o while fifo_empty_i=1 and SHALL assert it exactly once per frame.
REQ-016 tx_o SHALL be driven low from the edge that enters START, for exactly CLKS_PER_BIT cycles.
REQ-017 DATA SHALL shift out 8 bits LSB first, each held exactly CLKS_PER_BIT cycles.
REQ-018 PARITY SHALL drive the XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
REQ-019 STOP SHALL drive tx_o high for STOP_BITS*CLKS_PER_BIT cycles.
REQ-020 Bit timer SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary; a 3-bit counter SHALL index data bits 0..7.
REQ-021 Total frame length SHALL be (9 + PARITY_EN + STOP_BITS)*CLKS_PER_BIT cycles.
REQ-022 On the final cycle of the last stop bit, SHALL pulse done_o; if en_i=1 and fifo_empty_i=0 in that cycle, SHALL pop and go directly to START (zero idle gap), else go to IDLE.
REQ-023 Deasserting en_i mid-frame SHALL NOT abort or alter the current frame; only subsequent pops are suppressed.
REQ-024 fifo_rdata_i changes after the pop SHALL NOT affect the frame in progress.
REQ-025 busy_o SHALL be high in START, DATA, PARITY and STOP, and low in IDLE.

Reset
REQ-026 rst_i=1 SHALL immediately (asynchronously) force state=IDLE, tx_o=1, fifo_re_o=0, busy_o=0, done_o=0, and clear all counters and the shift register.
REQ-027 Reset mid-frame SHALL abandon the frame (the byte is lost, no done_o); after release the block SHALL resume from IDLE per REQ-014.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-028 Reset: assert rst_i between edges -> tx_o=1, busy_o=0, fifo_re_o=0, done_o=0 with no clock edge required.
REQ-029 Single byte 0xA5, no parity, 1 stop -> one fifo_re_o pulse; tx_o = 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; done_o pulses once 40 cycles after the start bit begins.
REQ-030 Back-to-back 0x00 then 0xFF -> second start bit directly follows first stop bit; pops are exactly 40 cycles apart; busy_o stays high for 80 cycles.
REQ-031 PARITY_EN=1, STOP_BITS=2, byte 0x07 -> parity bit=1; frame = 48 cycles; tx_o high during the final 8 cycles.
REQ-032 en_i dropped during DATA with FIFO non-empty -> frame completes with done_o; no further fifo_re_o until en_i=1 again.
REQ-033 rst_i pulsed during DATA bit 3 -> tx_o=1 immediately, no done_o; after release with en_i=1 and FIFO non-empty -> new pop, and the next byte is sent as a full frame.
